// File: rtl/cpu_defs.sv
// Shared encodings for the uncached access path: read FSM states,
// CPU size codes and the bus request type codes they map onto.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [2:0] TYPE_B = 3'b000;
    localparam logic [2:0] TYPE_H = 3'b001;
    localparam logic [2:0] TYPE_W = 3'b010;

    // Size code 3 is not a legal access width and is issued as a word.
    function automatic logic [2:0] bus_type(input logic [1:0] sz);
        logic [2:0] t;
        t = TYPE_W;
        case (sz)
            SZ_B:    t = TYPE_B;
            SZ_H:    t = TYPE_H;
            SZ_W:    t = TYPE_W;
            default: t = TYPE_W;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/uncache_wbuf.sv
// Single-entry posted store buffer; owns the bus write channel and
// reloads in the drain cycle so back-to-back stores leave no wr_req gap.
module uncache_wbuf
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_rdy,
    output logic              wb_valid,
    output logic              drain,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [DATA_W-1:0] wr_data
);

    assign drain  = wb_valid & wr_rdy;
    assign wr_req = wb_valid;

    // A push in the drain cycle overrides the clear and keeps the entry valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wr_type  <= TYPE_B;
            wr_addr  <= '0;
            wr_wstrb <= '0;
            wr_data  <= '0;
        end else if (push) begin
            wb_valid <= 1'b1;
            wr_type  <= bus_type(size);
            wr_addr  <= addr;
            wr_wstrb <= wstrb;
            wr_data  <= wdata;
        end else if (drain) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uncache_unit.sv
// Uncached access unit: posts stores through a one-entry write buffer and
// runs strictly ordered single-outstanding loads over the rd_*/ret_* bus.
module uncache_unit
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_req,
    output logic [2:0]        rd_type,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,
    output logic              wr_req,
    output logic [2:0]        wr_type,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_wstrb,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_rdy
);

    state_t            state;
    state_t            state_nxt;
    logic              wb_valid;
    logic              drain;
    logic              st_acc;
    logic              ld_acc;
    logic              st_ok;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_type;

    // Loads wait for an empty buffer; stores may refill it in the drain cycle.
    always_comb begin
        state_nxt = state;
        st_acc    = 1'b0;
        ld_acc    = 1'b0;
        case (state)
            IDLE: begin
                st_acc = resetn & req & wr & (~wb_valid | drain);
                ld_acc = resetn & req & ~wr & ~wb_valid;
                if (ld_acc) state_nxt = RD_REQ;
            end
            RD_REQ:  if (rd_rdy) state_nxt = RD_WAIT;
            RD_WAIT: if (ret_valid & ret_last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_ok = st_acc | ld_acc;
    assign data_ok = st_ok | (state == RESP);
    assign rd_req  = (state == RD_REQ);
    assign rd_addr = ld_addr;
    assign rd_type = ld_type;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            st_ok   <= 1'b0;
            rdata   <= '0;
            ld_addr <= '0;
            ld_type <= TYPE_B;
        end else begin
            state <= state_nxt;
            st_ok <= st_acc;
            if (ld_acc) begin
                ld_addr <= addr;
                ld_type <= bus_type(size);
            end
            // Every beat overwrites the capture so rdata ends on the last beat.
            if ((state == RD_WAIT) && ret_valid) rdata <= ret_data;
        end
    end

    uncache_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk      (clk),
        .resetn   (resetn),
        .push     (st_acc),
        .addr     (addr),
        .size     (size),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .wr_rdy   (wr_rdy),
        .wb_valid (wb_valid),
        .drain    (drain),
        .wr_req   (wr_req),
        .wr_type  (wr_type),
        .wr_addr  (wr_addr),
        .wr_wstrb (wr_wstrb),
        .wr_data  (wr_data)
    );

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: directed scenarios plus a randomized run checked
// against a word-memory reference model and transaction queues.
module tb_uncache_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NOPS = 300;
    localparam logic [31:0] RBASE = 32'h1FC0_0000;

    typedef struct { logic is_ld; logic [31:0] data; int due; } cpl_t;
    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [2:0] t; } st_t;
    typedef struct { logic [31:0] a; logic [2:0] t; } ld_t;

    logic          clk;
    logic          resetn;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;
    logic          rd_req;
    logic [2:0]    rd_type;
    logic [AW-1:0] rd_addr;
    logic          rd_rdy;
    logic          ret_valid;
    logic          ret_last;
    logic [DW-1:0] ret_data;
    logic          wr_req;
    logic [2:0]    wr_type;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_wstrb;
    logic [DW-1:0] wr_data;
    logic          wr_rdy;

    int total = 0;
    int bad   = 0;

    uncache_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] ty_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 3'b000 : (sz == 2'd1) ? 3'b001 : 3'b010;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'd0; addr = '0; wdata = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0; wr_rdy = 1'b0;
    endtask

    // Load with rd_rdy=1 and beats back-to-back from N+2; data_ok at N+2+nbeats.
    task automatic load_txn(input string nm, input logic [31:0] a, input logic [1:0] sz,
                            input logic [2:0] et, input int nbeats, input logic [31:0] last);
        req = 1'b1; wr = 1'b0; addr = a; size = sz; rd_rdy = 1'b1; #1;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL %s_addr_ok: got %b want 1", nm, addr_ok); end
        tick(); req = 1'b0; #1;
        total++;
        if ({rd_req, rd_type, rd_addr} !== {1'b1, et, a}) begin
            bad++; $display("FAIL %s_rd_req: got %b/%b/%h want 1/%b/%h", nm, rd_req, rd_type, rd_addr, et, a);
        end
        tick();
        for (int b = 0; b < nbeats; b++) begin
            ret_valid = 1'b1; ret_last = (b == nbeats - 1);
            ret_data = (b == nbeats - 1) ? last : ~last; #1;
            total++;
            if ({rd_req, data_ok} !== 2'b00) begin
                bad++; $display("FAIL %s_beat%0d: got rd_req/data_ok %b%b want 00", nm, b, rd_req, data_ok);
            end
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0; rd_rdy = 1'b0; #1;
        total++;
        if ({data_ok, rdata} !== {1'b1, last}) begin
            bad++; $display("FAIL %s_resp: got %b/%h want 1/%h", nm, data_ok, rdata, last);
        end
        tick(); #1;
        total++;
        if (data_ok !== 1'b0) begin bad++; $display("FAIL %s_pulse: got data_ok %b want 0", nm, data_ok); end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs(); resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1; #1;
        total++;
        if ({addr_ok, data_ok, rd_req, wr_req} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {addr_ok, data_ok, rd_req, wr_req});
        end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        tick();
    endtask

    task automatic test_single_load();
        load_txn("single_ld", 32'hBFD0_0000, 2'd2, 3'b010, 1, 32'h1234_5678);
    endtask

    task automatic test_store_wait();
        idle_inputs();
        req = 1'b1; wr = 1'b1; addr = 32'h9FC0_0010; size = 2'd1; wstrb = 4'b0011;
        wdata = 32'hAABB_CCDD; #1;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL st_addr_ok: got %b want 1", addr_ok); end
        tick(); req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_rdy = (i == 3); #1;
            total++;
            if ({wr_req, wr_addr, wr_type, wr_wstrb, wr_data} !==
                {1'b1, 32'h9FC0_0010, 3'b001, 4'b0011, 32'hAABB_CCDD}) begin
                bad++; $display("FAIL st_hold%0d: got %b %h %b %b %h want 1 9fc00010 001 0011 aabbccdd",
                                i, wr_req, wr_addr, wr_type, wr_wstrb, wr_data);
            end
            total++;
            if (data_ok !== (i == 0)) begin
                bad++; $display("FAIL st_data_ok%0d: got %b want %b", i, data_ok, (i == 0));
            end
            tick();
        end
        wr_rdy = 1'b0; #1;
        total++;
        if (wr_req !== 1'b0) begin bad++; $display("FAIL st_clear: got wr_req %b want 0", wr_req); end
        tick();
    endtask

    task automatic test_store_then_load();
        idle_inputs();
        req = 1'b1; wr = 1'b1; addr = 32'h9FC0_0020; size = 2'd2; wstrb = 4'hF;
        wdata = 32'h1111_2222; #1;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL sl_st_ok: got %b want 1", addr_ok); end
        tick();
        wr = 1'b0; rd_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_rdy = (i == 2); #1;
            total++;
            if ({addr_ok, rd_req} !== 2'b00) begin
                bad++; $display("FAIL sl_blocked%0d: got addr_ok/rd_req %b%b want 00", i, addr_ok, rd_req);
            end
            tick();
        end
        wr_rdy = 1'b0; #1;
        total++;
        if ({addr_ok, wr_req} !== 2'b10) begin
            bad++; $display("FAIL sl_ld_accept: got addr_ok/wr_req %b%b want 10", addr_ok, wr_req);
        end
        tick(); req = 1'b0; #1;
        total++;
        if ({rd_req, wr_req} !== 2'b10) begin
            bad++; $display("FAIL sl_rd_req: got rd_req/wr_req %b%b want 10", rd_req, wr_req);
        end
        tick(); ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h5555_AAAA;
        tick(); ret_valid = 1'b0; ret_last = 1'b0; rd_rdy = 1'b0; #1;
        total++;
        if ({data_ok, rdata} !== {1'b1, 32'h5555_AAAA}) begin
            bad++; $display("FAIL sl_resp: got %b/%h want 1/5555aaaa", data_ok, rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        req = 1'b1; wr = 1'b1; addr = 32'h9FC0_0100; size = 2'd2; wstrb = 4'hF;
        wdata = 32'hD1D1_D1D1; #1;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b want 1", addr_ok); end
        tick();
        addr = 32'h9FC0_0106; size = 2'd1; wstrb = 4'b1100; wdata = 32'hD2D2_0000; wr_rdy = 1'b1; #1;
        total++;
        if ({addr_ok, wr_req, wr_addr, wr_data} !== {2'b11, 32'h9FC0_0100, 32'hD1D1_D1D1}) begin
            bad++; $display("FAIL b2b_drain: got %b%b %h %h want 11 9fc00100 d1d1d1d1",
                            addr_ok, wr_req, wr_addr, wr_data);
        end
        tick(); req = 1'b0; wr_rdy = 1'b0; #1;
        total++;
        if ({wr_req, wr_addr, wr_wstrb, wr_type, wr_data} !==
            {1'b1, 32'h9FC0_0106, 4'b1100, 3'b001, 32'hD2D2_0000}) begin
            bad++; $display("FAIL b2b_second: got %b %h %b %b %h want 1 9fc00106 1100 001 d2d20000",
                            wr_req, wr_addr, wr_wstrb, wr_type, wr_data);
        end
        total++;
        if (data_ok !== 1'b1) begin bad++; $display("FAIL b2b_data_ok: got %b want 1", data_ok); end
        tick(); wr_rdy = 1'b1;
        tick(); wr_rdy = 1'b0; #1;
        total++;
        if (wr_req !== 1'b0) begin bad++; $display("FAIL b2b_empty: got wr_req %b want 0", wr_req); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        req = 1'b1; wr = 1'b1; addr = 32'h9FC0_0200; size = 2'd2; wstrb = 4'hF; wdata = 32'h7777_7777;
        tick(); req = 1'b0; resetn = 1'b0;
        tick(); resetn = 1'b1; #1;
        total++;
        if ({wr_req, data_ok} !== 2'b00) begin
            bad++; $display("FAIL rst_wbuf: got wr_req/data_ok %b%b want 00", wr_req, data_ok);
        end
        tick();
        req = 1'b1; wr = 1'b0; addr = 32'hBFD0_0040; size = 2'd2; rd_rdy = 1'b1; #1;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL rst_ld_accept: got %b want 1", addr_ok); end
        tick(); req = 1'b0;
        tick(); resetn = 1'b0;
        tick(); resetn = 1'b1; rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEAD_BEEF; #1;
        total++;
        if ({addr_ok, rd_req, data_ok, wr_req} !== 4'b0000) begin
            bad++; $display("FAIL rst_idle: got %b want 0000", {addr_ok, rd_req, data_ok, wr_req});
        end
        tick(); ret_valid = 1'b0; ret_last = 1'b0; #1;
        total++;
        if ({data_ok, rdata} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL rst_late_ret: got %b/%h want 0/0", data_ok, rdata);
        end
        tick();
        load_txn("post_rst", 32'hBFD0_0044, 2'd2, 3'b010, 1, 32'h0BAD_F00D);
    endtask

    task automatic test_load_sizes();
        load_txn("size3", 32'hBFD0_0008, 2'd3, 3'b010, 2, 32'hCAFE_F00D);
        load_txn("size0", 32'hBFD0_0013, 2'd0, 3'b000, 3, 32'h0102_0304);
    endtask

    task automatic test_random();
        logic [31:0] mem_ref [8];
        logic [31:0] mem_bus [8];
        cpl_t cq[$];
        st_t  sq[$];
        ld_t  lq[$];
        cpl_t c;
        st_t  s;
        ld_t  l;
        int   issued = 0;
        int   accepted = 0;
        int   sq_n0 = 0;
        int   beats = 0;
        bit   pend = 1'b0;
        bit   rd_out = 1'b0;
        logic        pwr = 1'b0;
        logic [1:0]  psz = 2'd0;
        logic [3:0]  pst = 4'd0;
        logic [2:0]  pidx = 3'd0;
        logic [2:0]  rd_idx = 3'd0;
        logic [31:0] pwd = 32'd0;
        logic [31:0] paddr = 32'd0;
        for (int i = 0; i < 8; i++) begin mem_ref[i] = $urandom; mem_bus[i] = mem_ref[i]; end
        idle_inputs();
        for (int cyc = 0; cyc < 20000 &&
             (accepted < NOPS || cq.size() != 0 || sq.size() != 0 || rd_out); cyc++) begin
            if (!pend && issued < NOPS && $urandom_range(0, 3) != 0) begin
                pend = 1'b1; issued++;
                pwr = 1'($urandom_range(0, 1)); psz = 2'($urandom_range(0, 3));
                pst = 4'($urandom_range(1, 15)); pidx = 3'($urandom_range(0, 7)); pwd = $urandom;
                paddr = RBASE | {27'd0, pidx, 2'b00};
            end
            req = pend; wr = pwr; size = psz; wstrb = pst; addr = paddr; wdata = pwd;
            wr_rdy = ($urandom_range(0, 2) != 0);
            rd_rdy = ($urandom_range(0, 2) != 0);
            ret_valid = 1'b0; ret_last = 1'b0; ret_data = $urandom;
            if (rd_out && $urandom_range(0, 3) != 0) begin
                ret_valid = 1'b1; ret_last = (beats == 1);
                if (beats == 1) ret_data = mem_bus[rd_idx];
            end
            #1;
            sq_n0 = sq.size();
            if (data_ok) begin
                total++;
                if (cq.size() == 0) begin
                    bad++; $display("FAIL rand_data_ok: got pulse at cycle %0d want none", cyc);
                end else begin
                    c = cq.pop_front();
                    total++;
                    if (c.is_ld && rdata !== c.data) begin
                        bad++; $display("FAIL rand_rdata: got %h want %h", rdata, c.data);
                    end else if (!c.is_ld && cyc != c.due) begin
                        bad++; $display("FAIL rand_st_ok_time: got cycle %0d want %0d", cyc, c.due);
                    end
                end
            end
            if (ret_valid) begin
                if (ret_last) rd_out = 1'b0;
                else beats--;
            end
            if (rd_req) begin
                total++;
                if (wr_req !== 1'b0) begin bad++; $display("FAIL rand_rd_vs_wb: got wr_req %b want 0", wr_req); end
                if (rd_rdy) begin
                    total++;
                    if (lq.size() == 0) begin
                        bad++; $display("FAIL rand_rd_spurious: got rd %h want none", rd_addr);
                    end else begin
                        l = lq.pop_front();
                        if ({rd_addr, rd_type} !== {l.a, l.t}) begin
                            bad++; $display("FAIL rand_rd_fields: got %h/%b want %h/%b", rd_addr, rd_type, l.a, l.t);
                        end
                    end
                    rd_out = 1'b1; beats = $urandom_range(1, 3); rd_idx = rd_addr[4:2];
                end
            end
            if (wr_req && wr_rdy) begin
                total++;
                if (sq.size() == 0) begin
                    bad++; $display("FAIL rand_wr_spurious: got wr %h want none", wr_addr);
                end else begin
                    s = sq.pop_front();
                    if ({wr_addr, wr_data, wr_wstrb, wr_type} !== {s.a, s.d, s.s, s.t}) begin
                        bad++; $display("FAIL rand_wr_fields: got %h %h %b %b want %h %h %b %b",
                                        wr_addr, wr_data, wr_wstrb, wr_type, s.a, s.d, s.s, s.t);
                    end
                end
                mem_bus[wr_addr[4:2]] = merge(mem_bus[wr_addr[4:2]], wr_data, wr_wstrb);
            end
            if (addr_ok) begin
                total++;
                if (!pend) begin
                    bad++; $display("FAIL rand_accept: got addr_ok with req=0 want 0");
                end else if (!pwr && sq_n0 != 0) begin
                    bad++; $display("FAIL rand_order: got load accepted with %0d buffered want 0", sq_n0);
                end
                if (pend) begin
                    if (pwr) begin
                        mem_ref[pidx] = merge(mem_ref[pidx], pwd, pst);
                        s.a = paddr; s.d = pwd; s.s = pst; s.t = ty_of(psz); sq.push_back(s);
                        c.is_ld = 1'b0; c.data = 32'h0; c.due = cyc + 1; cq.push_back(c);
                    end else begin
                        c.is_ld = 1'b1; c.data = mem_ref[pidx]; c.due = -1; cq.push_back(c);
                        l.a = paddr; l.t = ty_of(psz); lq.push_back(l);
                    end
                    pend = 1'b0; accepted++;
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        total++;
        if (accepted != NOPS || cq.size() != 0 || sq.size() != 0) begin
            bad++; $display("FAIL rand_complete: got accepted=%0d cq=%0d sq=%0d want %0d/0/0",
                            accepted, cq.size(), sq.size(), NOPS);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_single_load();
        test_store_wait();
        test_store_then_load();
        test_back_to_back();
        test_reset_mid();
        test_load_sizes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
